f1_timer: RTL and testbench

- Timing and reaction stage for the F1 start-light game.
- Consumes the light FSM's cmd_seq/cmd_delay and drives its en input.
- During the light sequence, en is a 1-cycle tick every TICK_DIV cycles.
- After all lights are on, it waits a pseudo-random number of ticks, pulses en once to turn the lights out, then measures the player's reaction time in clock cycles.
- A button press during the random hold is reported as a false start.

---
 rtl/f1_timer.sv | 171 +++++++++++++++++
 tb/tb_f1_timer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_timer.sv
// f1_timer: timing and reaction stage for the F1 start-light game.
//
// Paces the light FSM with a 1-cycle step pulse every TICK_DIV cycles while
// it steps through the lights. Once all lights are lit, it waits a
// pseudo-random number of ticks and pulses en once more to put the lights
// out. It then counts clock cycles until the player presses the button.
// A press during the random hold is flagged as a false start.
//
// Ports:
//   clk          system clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   cmd_seq      light FSM is stepping lights (some lit, not all)
//   cmd_delay    light FSM has all 8 lights lit
//   btn          player button, synchronised and debounced, active high
//   en           step pulse to the light FSM
//   lights_out   1-cycle pulse coincident with the final en of a run
//   react_time   last measured reaction time in clock cycles
//   react_valid  react_time holds a result for the current run
//   false_start  button was pressed during the random hold
module f1_timer #(
    parameter int unsigned       TICK_DIV  = 50,
    parameter int unsigned       LFSR_W    = 7,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1),
    parameter int unsigned       REACT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_seq,
    input  logic               cmd_delay,
    input  logic               btn,
    output logic               en,
    output logic               lights_out,
    output logic [REACT_W-1:0] react_time,
    output logic               react_valid,
    output logic               false_start
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEQ,
        S_DELAY,
        S_REACT
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [LFSR_W-1:0]    delay_q, delay_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [REACT_W-1:0]   react_cnt_q, react_cnt_d;
    logic [REACT_W-1:0]   react_time_q, react_time_d;
    logic                 react_valid_q, react_valid_d;
    logic                 false_start_q, false_start_d;

    logic                 tick_last;
    logic [TICK_W-1:0]    tick_next;
    logic                 hold_expired;

    // Fibonacci LFSR, x^7+x^6+1; free-running so the hold length depends on
    // when the light FSM finishes its sequence.
    assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};

    assign tick_last    = (tick_q == TICK_LAST);
    assign tick_next    = tick_last ? '0 : tick_q + TICK_W'(1);
    assign hold_expired = tick_last && (delay_q == LFSR_W'(1));

    assign react_time  = react_time_q;
    assign react_valid = react_valid_q;
    assign false_start = false_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tick_q        <= '0;
            delay_q       <= '0;
            lfsr_q        <= LFSR_SEED;
            react_cnt_q   <= '0;
            react_time_q  <= '0;
            react_valid_q <= 1'b0;
            false_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            delay_q       <= delay_d;
            lfsr_q        <= lfsr_d;
            react_cnt_q   <= react_cnt_d;
            react_time_q  <= react_time_d;
            react_valid_q <= react_valid_d;
            false_start_q <= false_start_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        delay_d       = delay_q;
        react_cnt_d   = react_cnt_q;
        react_time_d  = react_time_q;
        react_valid_d = react_valid_q;
        false_start_d = false_start_q;
        en            = 1'b0;
        lights_out    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (cmd_seq) begin
                    state_d       = S_SEQ;
                    react_valid_d = 1'b0;
                    false_start_d = 1'b0;
                end
            end

            S_SEQ: begin
                en     = tick_last;
                tick_d = tick_next;
                if (cmd_delay) begin
                    state_d = S_DELAY;
                    tick_d  = '0;
                    delay_d = lfsr_q;
                end else if (!cmd_seq) begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            end

            S_DELAY: begin
                tick_d = tick_next;
                if (tick_last) begin
                    delay_d = delay_q - LFSR_W'(1);
                end
                // A press wins over expiry: en still clears the lights, but
                // the run is scored as a false start, not a lights-out.
                if (btn) begin
                    en            = 1'b1;
                    false_start_d = 1'b1;
                    state_d       = S_IDLE;
                    tick_d        = '0;
                end else if (hold_expired) begin
                    en          = 1'b1;
                    lights_out  = 1'b1;
                    state_d     = S_REACT;
                    tick_d      = '0;
                    react_cnt_d = '0;
                end else if (!cmd_delay) begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            end

            S_REACT: begin
                if (!(&react_cnt_q)) begin
                    react_cnt_d = react_cnt_q + REACT_W'(1);
                end
                if (btn) begin
                    react_time_d  = react_cnt_q;
                    react_valid_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_f1_timer.sv
// Bench for f1_timer. Two instances with TICK_DIV=4 share the stimulus:
// dut_a uses a 16-bit reaction counter, dut_b a 4-bit one for saturation.
module tb_f1_timer;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_seq = 1'b0;
    logic        cmd_delay = 1'b0;
    logic        btn = 1'b0;

    logic        en_a, lo_a, rv_a, fs_a;
    logic [15:0] rt_a;
    logic        en_b, lo_b, rv_b, fs_b;
    logic [3:0]  rt_b;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc;
    logic [6:0]  lfsr_tbl [127];

    f1_timer #(.TICK_DIV(TD), .LFSR_W(7), .LFSR_SEED(7'h01), .REACT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay), .btn(btn),
        .en(en_a), .lights_out(lo_a), .react_time(rt_a), .react_valid(rv_a),
        .false_start(fs_a)
    );

    f1_timer #(.TICK_DIV(TD), .LFSR_W(7), .LFSR_SEED(7'h01), .REACT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay), .btn(btn),
        .en(en_b), .lights_out(lo_b), .react_time(rt_b), .react_valid(rv_b),
        .false_start(fs_b)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release; the random source is a pure
    // function of this count.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] lfsr_now();
        return lfsr_tbl[cyc % 127];
    endfunction

    // Inputs for one cycle, applied at the negedge; outputs settle 1 ns later.
    task automatic drive(input logic s, input logic d, input logic b);
        @(negedge clk);
        cmd_seq = s; cmd_delay = d; btn = b;
        #1;
    endtask

    // IDLE cycle, nseq SEQ cycles, one SEQ cycle raising cmd_delay, then the
    // hold. fs_sel: 0 no press, <0 press on the expiry cycle, else press on
    // hold cycle 1 + fs_sel % (TD*d).
    task automatic enter_and_hold(input int nseq, input int fs_sel, output int d);
        int hold, fs;
        drive(1, 0, 0);
        for (int k = 1; k <= nseq; k++) begin
            drive(1, 0, 0);
            checks++;
            if (en_a !== logic'(k % TD == 0)) begin
                errors++;
                $display("FAIL run_seq_en k=%0d: en=%b required %b", k, en_a, k % TD == 0);
            end
        end
        drive(0, 1, 0);
        d = int'(lfsr_now());
        checks++;
        if (en_a !== logic'((nseq + 1) % TD == 0) || fs_a !== 1'b0 || rv_a !== 1'b0) begin
            errors++;
            $display("FAIL run_seq_entry: en=%b fs=%b rv=%b required en=%b fs=0 rv=0",
                     en_a, fs_a, rv_a, (nseq + 1) % TD == 0);
        end
        hold = TD * d;
        fs = (fs_sel == 0) ? 0 : (fs_sel < 0) ? hold : 1 + (fs_sel % hold);
        for (int j = 1; j <= hold; j++) begin
            drive(0, 1, j == fs);
            checks++;
            if (en_a !== logic'(j == hold || j == fs) || lo_a !== logic'(j == hold && j != fs)) begin
                errors++;
                $display("FAIL hold_pulse j=%0d d=%0d: en=%b lo=%b required en=%b lo=%b",
                         j, d, en_a, lo_a, j == hold || j == fs, j == hold && j != fs);
            end
            if (j == fs) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if ({en_a, lo_a, rv_a, fs_a, en_b, lo_b, rv_b, fs_b} !== 8'h00 ||
                rt_a !== 16'd0 || rt_b !== 4'd0) begin
                errors++;
                $display("FAIL reset_outputs: en=%b lo=%b rv=%b fs=%b rt=%0d required all 0",
                         en_a, lo_a, rv_a, fs_a, rt_a);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; cmd_seq = 1'b1; cmd_delay = 1'b0; btn = 1'b0;
        #1;
        checks++;
        if ({en_a, lo_a, rv_a, fs_a} !== 4'h0 || rt_a !== 16'd0) begin
            errors++;
            $display("FAIL release_outputs: en=%b lo=%b rv=%b fs=%b required 0", en_a, lo_a, rv_a, fs_a);
        end
        // Seed 7'h01 steps once to 2 by the first SEQ cycle: 8-cycle hold.
        drive(0, 1, 0);
        for (int j = 1; j <= 8; j++) begin
            drive(0, 1, 0);
            checks++;
            if (lo_a !== logic'(j == 8) || en_a !== logic'(j == 8)) begin
                errors++;
                $display("FAIL seed_hold j=%0d: lo=%b en=%b required %b", j, lo_a, en_a, j == 8);
            end
        end
        for (int r = 1; r <= 5; r++) drive(0, 0, r == 5);
        drive(0, 0, 0);
        checks++;
        if (rt_a !== 16'd4 || rv_a !== 1'b1) begin
            errors++;
            $display("FAIL seed_react: rt=%0d rv=%b required 4 1", rt_a, rv_a);
        end
    endtask

    task automatic test_sequence();
        drive(1, 0, 0);
        for (int k = 1; k <= 28; k++) begin
            drive(1, 0, 0);
            checks++;
            if (en_a !== logic'(k % 4 == 0)) begin
                errors++;
                $display("FAIL seq_en k=%0d: en=%b required %b", k, en_a, k % 4 == 0);
            end
            if (k == 1) begin
                checks++;
                if (rv_a !== 1'b0 || rt_a !== 16'd4) begin
                    errors++;
                    $display("FAIL seq_clear: rv=%b rt=%0d required 0 4", rv_a, rt_a);
                end
            end
        end
    endtask

    task automatic test_hold();
        int  k = 29;
        bit  hit = 0;
        for (int g = 0; g < 300 && !hit; g++) begin
            @(negedge clk);
            hit = (lfsr_now() == 7'd5);
            cmd_seq = !hit; cmd_delay = hit; btn = 1'b0;
            #1;
            checks++;
            if (en_a !== logic'(k % 4 == 0)) begin
                errors++;
                $display("FAIL hold_seq_en k=%0d: en=%b required %b", k, en_a, k % 4 == 0);
            end
            k++;
        end
        if (!hit) begin
            errors++;
            $display("FAIL hold_wait: lfsr model never read 5 (required within 300 cycles)");
        end
        for (int j = 1; j <= 20; j++) begin
            drive(0, 1, 0);
            checks++;
            if (en_a !== logic'(j == 20) || lo_a !== logic'(j == 20)) begin
                errors++;
                $display("FAIL hold5 j=%0d: en=%b lo=%b required %b", j, en_a, lo_a, j == 20);
            end
        end
    endtask

    task automatic test_react();
        int n;
        for (int r = 1; r <= 37; r++) begin
            drive(0, 0, r == 37);
            checks++;
            if (en_a !== 1'b0 || lo_a !== 1'b0) begin
                errors++;
                $display("FAIL react_en r=%0d: en=%b lo=%b required 0", r, en_a, lo_a);
            end
        end
        n = $urandom_range(2, 6);
        for (int i = 0; i <= n; i++) begin
            drive(0, 0, 1'($urandom));
            checks++;
            if (rt_a !== 16'd36 || rv_a !== 1'b1 || fs_a !== 1'b0) begin
                errors++;
                $display("FAIL react_hold i=%0d: rt=%0d rv=%b fs=%b required 36 1 0", i, rt_a, rv_a, fs_a);
            end
        end
        drive(1, 0, 0);
        drive(1, 0, 0);
        checks++;
        if (rv_a !== 1'b0 || rt_a !== 16'd36) begin
            errors++;
            $display("FAIL react_clear: rv=%b rt=%0d required 0 36", rv_a, rt_a);
        end
        drive(0, 0, 0);
    endtask

    task automatic test_first_react();
        int d;
        enter_and_hold(0, 0, d);
        drive(0, 0, 1);
        drive(0, 0, 0);
        checks++;
        if (rt_a !== 16'd0 || rv_a !== 1'b1) begin
            errors++;
            $display("FAIL first_react: rt=%0d rv=%b required 0 1", rt_a, rv_a);
        end
    endtask

    task automatic test_saturation();
        int d;
        enter_and_hold(2, 0, d);
        for (int r = 1; r <= 30; r++) drive(0, 0, r == 30);
        drive(0, 0, 0);
        checks++;
        if (rt_b !== 4'd15 || rv_b !== 1'b1 || rt_a !== 16'd29) begin
            errors++;
            $display("FAIL react_saturate: rt_b=%0d rv_b=%b rt_a=%0d required 15 1 29", rt_b, rv_b, rt_a);
        end
    endtask

    task automatic test_false_start();
        int d;
        enter_and_hold(5, 2, d);
        drive(0, 1, 0);
        checks++;
        if (fs_a !== 1'b1 || rv_a !== 1'b0 || en_a !== 1'b0 || lo_a !== 1'b0 || rt_a !== 16'd29) begin
            errors++;
            $display("FAIL false_start: fs=%b rv=%b en=%b lo=%b rt=%0d required 1 0 0 0 29",
                     fs_a, rv_a, en_a, lo_a, rt_a);
        end
        for (int i = 0; i < TD * (d + 1); i++) begin
            drive(0, 1, 0);
            checks++;
            if (en_a !== 1'b0 || lo_a !== 1'b0) begin
                errors++;
                $display("FAIL fs_idle i=%0d: en=%b lo=%b required 0", i, en_a, lo_a);
            end
        end
        drive(0, 0, 0);
        enter_and_hold(1, -1, d);
        drive(0, 0, 0);
        checks++;
        if (fs_a !== 1'b1 || rv_a !== 1'b0) begin
            errors++;
            $display("FAIL fs_at_expiry: fs=%b rv=%b required 1 0", fs_a, rv_a);
        end
    endtask

    task automatic test_abort();
        int d;
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        #2 btn = 1'b1;
        #1;
        checks++;
        if (en_a !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: en=%b required 1", en_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en_a, lo_a, rv_a, fs_a} !== 4'h0 || rt_a !== 16'd0) begin
            errors++;
            $display("FAIL abort_reset: en=%b lo=%b rv=%b fs=%b rt=%0d required all 0",
                     en_a, lo_a, rv_a, fs_a, rt_a);
        end
        drive(0, 1, 1);
        @(negedge clk);
        rst_n = 1'b1; cmd_seq = 1'b1; cmd_delay = 1'b0; btn = 1'b0;
        #1;
        drive(0, 1, 0);
        for (int j = 1; j <= 8; j++) begin
            drive(0, 1, 0);
            checks++;
            if (lo_a !== logic'(j == 8)) begin
                errors++;
                $display("FAIL fresh_hold j=%0d: lo=%b required %b", j, lo_a, j == 8);
            end
        end
        drive(0, 0, 1);
        drive(0, 0, 0);
        // Upstream drops cmd_seq after 3 SEQ cycles.
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0);
            checks++;
            if (en_a !== 1'b0 || rv_a !== 1'b0 || fs_a !== 1'b0) begin
                errors++;
                $display("FAIL seq_abort i=%0d: en=%b rv=%b fs=%b required 0", i, en_a, rv_a, fs_a);
            end
        end
        // Upstream drops cmd_delay in the second hold cycle.
        drive(1, 0, 0);
        drive(0, 1, 0);
        d = int'(lfsr_now());
        drive(0, 1, 0);
        drive(0, 0, 0);
        for (int i = 0; i < TD * d; i++) begin
            drive(0, 0, 0);
            checks++;
            if (en_a !== 1'b0 || lo_a !== 1'b0 || fs_a !== 1'b0 || rv_a !== 1'b0) begin
                errors++;
                $display("FAIL delay_abort i=%0d: en=%b lo=%b fs=%b rv=%b required 0",
                         i, en_a, lo_a, fs_a, rv_a);
            end
        end
    endtask

    task automatic test_random();
        int d, p, exp_rt;
        exp_rt = 0;
        for (int run = 0; run < 10; run++) begin
            if ($urandom_range(0, 2) == 0) begin
                enter_and_hold($urandom_range(0, 9), $urandom_range(1, 1000), d);
                drive(0, 0, 0);
                checks++;
                if (fs_a !== 1'b1 || rv_a !== 1'b0 || (run > 0 && rt_a !== 16'(exp_rt))) begin
                    errors++;
                    $display("FAIL rand_fs run=%0d: fs=%b rv=%b rt=%0d required 1 0 %0d",
                             run, fs_a, rv_a, rt_a, exp_rt);
                end
            end else begin
                enter_and_hold($urandom_range(0, 9), 0, d);
                p = $urandom_range(1, 40);
                for (int r = 1; r <= p; r++) drive(0, 0, r == p);
                drive(0, 0, 0);
                exp_rt = p - 1;
                checks++;
                if (rt_a !== 16'(exp_rt) || rv_a !== 1'b1 || fs_a !== 1'b0 ||
                    rt_b !== 4'((exp_rt > 15) ? 15 : exp_rt)) begin
                    errors++;
                    $display("FAIL rand_react run=%0d: rt=%0d rt_b=%0d rv=%b fs=%b required %0d",
                             run, rt_a, rt_b, rv_a, fs_a, exp_rt);
                end
            end
        end
    endtask

    initial begin
        logic [6:0] v;
        v = 7'h01;
        for (int i = 0; i < 127; i++) begin
            lfsr_tbl[i] = v;
            v = 7'(((int'(v) << 1) & 127) | (((int'(v) >> 6) ^ (int'(v) >> 5)) & 1));
        end
        test_reset();
        test_sequence();
        test_hold();
        test_react();
        test_first_react();
        test_saturation();
        test_false_start();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
